// File: rtl/axis_udp_filter_arb.sv
// Frame-level round-robin arbiter feeding one AXI-Stream UDP filter input from NUM_PORTS sources.
// Optional stall abort/drain logic is compiled in with `define AXIS_UDP_FILTER_ARB_TIMEOUT_EN.
module axis_udp_filter_arb #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                       axis_clk,
    input  logic                                       axis_s_rst_n,
    input  logic                                       en,
    input  logic [NUM_PORTS-1:0]                       s_axis_tvalid,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS*(AXIS_DATA_WIDTH/8)-1:0]   s_axis_tstrb,
    input  logic [NUM_PORTS-1:0]                       s_axis_tlast,
    output logic [NUM_PORTS-1:0]                       s_axis_tready,
    output logic                                       m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]               m_axis_tstrb,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready,
    output logic [NUM_PORTS-1:0]                       grant_o,
    output logic                                       busy_o,
    output logic                                       timeout_o
);

    localparam int unsigned STRB_W = AXIS_DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_PORTS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
    localparam logic [1:0] ABORT = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
`endif

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("axis_udp_filter_arb: parameter out of range");
    end

    logic [1:0]             state_q;
    logic [IDX_W-1:0]       last_q;   // also the index of the current grant while busy
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    int unsigned            cand;

    logic                   g_valid;
    logic                   g_last;
    logic [AXIS_DATA_WIDTH-1:0] g_data;
    logic [STRB_W-1:0]      g_strb;
    logic                   hs;

    assign g_valid = s_axis_tvalid[last_q];
    assign g_last  = s_axis_tlast[last_q];
    assign g_data  = s_axis_tdata[last_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign g_strb  = s_axis_tstrb[last_q*STRB_W +: STRB_W];
    assign hs      = m_axis_tvalid & m_axis_tready;
    assign busy_o  = (state_q != IDLE);

    // Search starts just after the previous winner so every requester is served in turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = (32'(last_q) + k) % NUM_PORTS;
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            SEND: begin
                m_axis_tvalid         = g_valid;
                m_axis_tdata          = g_data;
                m_axis_tstrb          = g_strb;
                m_axis_tlast          = g_last;
                s_axis_tready[last_q] = m_axis_tready;
            end
`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
            end
            DRAIN: s_axis_tready[last_q] = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
    logic [15:0] stall_q;

    always_ff @(posedge axis_clk) begin
        if (!axis_s_rst_n) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_PORTS - 1);
            grant_o   <= '0;
            stall_q   <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state_q)
                IDLE: if (en && pick_found) begin
                    state_q <= SEND;
                    last_q  <= pick_idx;
                    grant_o <= NUM_PORTS'(1) << pick_idx;
                    stall_q <= '0;
                end
                SEND: begin
                    if (hs && m_axis_tlast) begin
                        state_q <= IDLE;
                        grant_o <= '0;
                    end else if (hs) begin
                        stall_q <= '0;
                    end else if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= ABORT;
                    end else begin
                        stall_q <= stall_q + 16'd1;
                    end
                end
                ABORT: if (m_axis_tready) begin
                    state_q   <= DRAIN;
                    timeout_o <= 1'b1;
                end
                DRAIN: if (g_valid && g_last) begin
                    state_q <= IDLE;
                    grant_o <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign timeout_o = 1'b0;

    always_ff @(posedge axis_clk) begin
        if (!axis_s_rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            grant_o <= '0;
        end else begin
            case (state_q)
                IDLE: if (en && pick_found) begin
                    state_q <= SEND;
                    last_q  <= pick_idx;
                    grant_o <= NUM_PORTS'(1) << pick_idx;
                end
                SEND: if (hs && m_axis_tlast) begin
                    state_q <= IDLE;
                    grant_o <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_axis_udp_filter_arb.sv
// Scoreboard bench for axis_udp_filter_arb: queued source frames, expected beats checked by a monitor.
module tb_axis_udp_filter_arb;

    localparam int NP = 4;
    localparam int W  = 64;
    localparam int SW = W / 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP*W-1:0]    s_axis_tdata;
    logic [NP*SW-1:0]   s_axis_tstrb;
    logic [NP-1:0]      s_axis_tlast;
    logic [NP-1:0]      s_axis_tready;
    logic               m_axis_tvalid;
    logic [W-1:0]       m_axis_tdata;
    logic [SW-1:0]      m_axis_tstrb;
    logic               m_axis_tlast;
    logic               m_axis_tready;
    logic [NP-1:0]      grant_o;
    logic               busy_o;
    logic               timeout_o;

    axis_udp_filter_arb #(
        .NUM_PORTS(NP),
        .AXIS_DATA_WIDTH(W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .axis_clk(clk),
        .axis_s_rst_n(rst_n),
        .en(en),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] strb;
        logic          last;
        int            hold;
    } beat_t;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] strb;
        logic          last;
        logic [NP-1:0] grant;
    } exp_t;

    beat_t src_q[NP][$];
    exp_t  exp_q[$];
    int    hs_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int to_pulses = 0;
    logic [NP-1:0] adv = '0;
    logic rdy_toggle = 1'b0;
    logic chk_mirror = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic push_beat(input int p, input logic [W-1:0] d, input logic [SW-1:0] s,
                             input logic l, input int hold, input bit fwd);
        beat_t b;
        exp_t e;
        b.data = d; b.strb = s; b.last = l; b.hold = hold;
        src_q[p].push_back(b);
        if (fwd) begin
            e.data = d; e.strb = s; e.last = l;
            e.grant = NP'(1) << p;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int p, input int fid, input int b);
        return {16'hC0DE, 8'(p), 8'(fid), 24'h0, 8'(b)};
    endfunction

    task automatic send_frame(input int p, input int n, input int fid);
        for (int b = 0; b < n; b++)
            push_beat(p, mk_data(p, fid, b), (b == n - 1) ? 8'h3F : 8'hFF, b == n - 1, 0, 1'b1);
    endtask

    function automatic bit sources_empty();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !sources_empty() || busy_o) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, n >= budget, 1'b0);
        tick(2);
    endtask

    // Source driver: presents queued beats per port, advancing on observed handshakes.
    initial begin
        bit loaded[NP];
        int hcnt[NP];
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin loaded[p] = 1'b0; hcnt[p] = 0; end
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (adv[p] && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    loaded[p] = 1'b0;
                end
                s_axis_tvalid[p] = 1'b0;
                if (src_q[p].size() == 0) begin
                    loaded[p] = 1'b0;
                end else begin
                    if (!loaded[p]) begin
                        hcnt[p]   = src_q[p][0].hold;
                        loaded[p] = 1'b1;
                    end
                    if (hcnt[p] > 0) begin
                        hcnt[p]--;
                    end else begin
                        s_axis_tvalid[p]          = 1'b1;
                        s_axis_tdata[p*W +: W]    = src_q[p][0].data;
                        s_axis_tstrb[p*SW +: SW]  = src_q[p][0].strb;
                        s_axis_tlast[p]           = src_q[p][0].last;
                    end
                end
            end
            m_axis_tready = rdy_toggle ? ~m_axis_tready : 1'b1;
        end
    end

    // Monitor: samples just before each rising edge and scores every master handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            adv = s_axis_tvalid & s_axis_tready;
            if (timeout_o) to_pulses++;
            check("tready_ungranted", 64'(s_axis_tready & ~grant_o), 64'd0);
            if (chk_mirror && busy_o)
                check("tready_mirror", 64'(s_axis_tready), 64'(grant_o & {NP{m_axis_tready}}));
            if (m_axis_tvalid && m_axis_tready) begin
                hs_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h grant %b, expected no beat",
                             m_axis_tdata, grant_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_strb", 64'(m_axis_tstrb), 64'(e.strb));
                    check("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    check("beat_grant", 64'(grant_o), 64'(e.grant));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        en    = 1'b1;
        tick(3);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_sready", 64'(s_axis_tready), 64'd0);
        check("rst_mlast", 64'(m_axis_tlast), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // All four ports request together: order 0,1,2,3, 3 beats each, one bubble between.
        hs_log.delete();
        for (int p = 0; p < NP; p++) send_frame(p, 3, 1);
        wait_done("t1_done", 200);
        check("t1_beats", 64'(hs_log.size()), 64'd12);
        if (hs_log.size() == 12) begin
            check("t1_span", 64'(hs_log[11] - hs_log[0]), 64'd14);
            check("t1_gap", 64'(hs_log[3] - hs_log[2]), 64'd2);
        end

        // Port 2 alone with a toggling master ready.
        chk_mirror = 1'b1;
        rdy_toggle = 1'b1;
        send_frame(2, 5, 2);
        wait_done("t2_done", 200);
        rdy_toggle = 1'b0;
        chk_mirror = 1'b0;
        tick(2);

        // Enable gating: reset so port 1 is found before port 3.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        en = 1'b0;
        send_frame(1, 4, 3);
        send_frame(3, 2, 3);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_en_low_grant", 64'(grant_o), 64'd0);
        end
        en = 1'b1;
        tick(1);
        check("t3_grant_p1", 64'(grant_o), 64'b0010);
        en = 1'b0;
        n = 0;
        while (exp_q.size() > 2 && n < 100) begin tick(1); n++; end
        check("t3_frame_complete", n >= 100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t3_no_regrant", 64'(grant_o), 64'd0);
        end
        en = 1'b1;
        wait_done("t3_done", 200);

        // Back-to-back port 0 frames interleave with port 3.
        send_frame(0, 2, 4);
        send_frame(3, 2, 4);
        send_frame(0, 2, 5);
        send_frame(3, 2, 5);
        wait_done("t4_done", 200);

`ifdef AXIS_UDP_FILTER_ARB_TIMEOUT_EN
        // Port 1 stalls mid-frame: drop marker, one timeout pulse, rest of frame drained.
        to_pulses = 0;
        push_beat(1, mk_data(1, 6, 0), 8'hFF, 1'b0, 0, 1'b1);
        begin
            exp_t e;
            e.data = '0; e.strb = '0; e.last = 1'b1; e.grant = 4'b0010;
            exp_q.push_back(e);
        end
        push_beat(1, mk_data(1, 6, 1), 8'hFF, 1'b0, 10, 1'b0);
        push_beat(1, mk_data(1, 6, 2), 8'hFF, 1'b1, 0, 1'b0);
        wait_done("t5_done", 200);
        check("t5_timeout_pulses", 64'(to_pulses), 64'd1);
        send_frame(1, 2, 7);
        wait_done("t5_regrant", 200);
`else
        check("no_timeout_pulse", 64'(to_pulses), 64'd0);
`endif

        // Reset on the second beat of a 4-beat port 2 frame.
        base = hs_log.size();
        push_beat(2, mk_data(2, 8, 0), 8'hFF, 1'b0, 0, 1'b1);
        push_beat(2, mk_data(2, 8, 1), 8'hFF, 1'b0, 0, 1'b1);
        push_beat(2, mk_data(2, 8, 2), 8'hFF, 1'b0, 0, 1'b0);
        push_beat(2, mk_data(2, 8, 3), 8'h3F, 1'b1, 0, 1'b0);
        n = 0;
        while (hs_log.size() < base + 1 && n < 100) begin tick(1); n++; end
        check("t6_first_beat", n >= 100, 1'b0);
        rst_n = 1'b0;
        tick(1);
        check("t6_grant", 64'(grant_o), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_sready", 64'(s_axis_tready), 64'd0);
        check("t6_mvalid", 64'(m_axis_tvalid), 64'd0);
        src_q[2].delete();
        tick(2);
        rst_n = 1'b1;
        send_frame(2, 2, 9);
        send_frame(0, 2, 9);
        begin
            exp_t e;
            // Port 0 must win after reset, so its frame precedes port 2's.
            exp_q.delete();
            e.grant = 4'b0001; e.strb = 8'hFF; e.last = 1'b0; e.data = mk_data(0, 9, 0);
            exp_q.push_back(e);
            e.strb = 8'h3F; e.last = 1'b1; e.data = mk_data(0, 9, 1);
            exp_q.push_back(e);
            e.grant = 4'b0100; e.strb = 8'hFF; e.last = 1'b0; e.data = mk_data(2, 9, 0);
            exp_q.push_back(e);
            e.strb = 8'h3F; e.last = 1'b1; e.data = mk_data(2, 9, 1);
            exp_q.push_back(e);
        end
        wait_done("t6_done", 200);

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_udp_filter_arb.md
Name: axis_udp_filter_arb

Overview:
- Frame-level round-robin arbiter that shares one 64-bit AXI-Stream UDP filter input between NUM_PORTS requesters (MAC RX lanes, loopback, CPU inject).
- Grants one input per frame, holds the grant until the tlast handshake, then re-arbitrates.
- Sits in front of the UDP filter. Its master port drives the filter's slave AXI-Stream port.

Parameters:
- NUM_PORTS, 4, number of slave AXI-Stream inputs (2..8).
- AXIS_DATA_WIDTH, 64, tdata width. tstrb width is AXIS_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, stall limit used only when the optional feature is compiled in (>=2).

Ports:
- axis_clk  in  1  clock; all logic is on the rising edge.
- axis_s_rst_n  in  1  reset; synchronous, active-low.
- en  in  1  arbitration enable; while low, no new grant is issued.
- s_axis_tvalid  in  NUM_PORTS  per-input valid; bit i is port i.
- s_axis_tdata  in  NUM_PORTS*AXIS_DATA_WIDTH  per-input data; port i is slice [i*W +: W].
- s_axis_tstrb  in  NUM_PORTS*AXIS_DATA_WIDTH/8  per-input strobes; sliced the same way.
- s_axis_tlast  in  NUM_PORTS  per-input last.
- s_axis_tready  out  NUM_PORTS  per-input ready.
- m_axis_tvalid  out  1  to filter.
- m_axis_tdata  out  AXIS_DATA_WIDTH  to filter.
- m_axis_tstrb  out  AXIS_DATA_WIDTH/8  to filter.
- m_axis_tlast  out  1  to filter.
- m_axis_tready  in  1  from filter.
- grant_o  out  NUM_PORTS  one-hot current grant; all zero when nothing is granted.
- busy_o  out  1  high while a frame is in progress.
- timeout_o  out  1  one-cycle pulse when a frame is aborted (optional feature only).

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer last_q = NUM_PORTS-1, so port 0 has the highest priority after reset.
- States: IDLE, SEND, plus ABORT and DRAIN when the optional feature is enabled.
- IDLE:
  - s_axis_tready = 0 and m_axis_tvalid = 0.
  - If en = 1 and any s_axis_tvalid bit is set, pick the first requesting port searching last_q+1, last_q+2, ... modulo NUM_PORTS.
  - Register the pick into grant_o and last_q, then go to SEND.
  - Grant latency: 1 cycle from request to the first possible beat.
- SEND, for granted port g (combinational path, no data register):
  - m_axis_tvalid/tdata/tstrb/tlast are port g's signals.
  - s_axis_tready[g] = m_axis_tready; s_axis_tready is 0 for every other port.
  - busy_o = 1.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast: go to IDLE and clear grant_o. This leaves one bubble cycle between frames.
- en is sampled only in IDLE. Dropping en in SEND does not cut a frame; the current frame completes.
- Requests that are valid but not granted are not acknowledged; their tready stays 0.
- A single requester is re-granted after its frame with 1 idle cycle between frames.
- Reset asserted mid-frame returns the block to reset values on the next edge. The partial frame on the master side is not terminated; the filter is reset by the same signal.
- tstrb is passed through unmodified. The arbiter does not interpret frame contents.

Optional Feature:
- Macro: AXIS_UDP_FILTER_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit stall counter clears on every handshake in SEND and increments on every SEND cycle with no handshake.
  - When the counter reaches TIMEOUT_CYCLES-1, go to ABORT.
  - ABORT drives m_axis_tvalid=1, tlast=1, tdata=0, tstrb=0 and holds it until m_axis_tready. The all-zero-strobe last beat is the filter's drop marker.
  - On that handshake, pulse timeout_o for 1 cycle and go to DRAIN.
  - DRAIN drives s_axis_tready[g]=1 and m_axis_tvalid=0, discarding port g's beats until a beat with tlast, then goes to IDLE.
- Without the macro: no counter, no ABORT or DRAIN states, timeout_o is tied to 0, and a stalled frame holds the grant indefinitely.

Test Plan:
- Reset, then all 4 ports present a 3-beat frame simultaneously with m_axis_tready=1 → frames appear on the master port in order 0,1,2,3. Each frame is 3 beats with tlast on beat 3 and 1 idle cycle between frames. grant_o runs 0001, 0010, 0100, 1000.
- Port 2 frame of 5 beats, with m_axis_tready toggling 1,0,1,0… → 5 beats delivered. s_axis_tready[2] mirrors m_axis_tready. Ports 0,1,3 have tready=0 throughout.
- en=0 while ports 1 and 3 are valid → grant_o stays 0 for 10 cycles. en=1 → port 1 is granted on the next cycle. Deassert en mid-frame → the frame still completes.
- Port 0 sends back-to-back 2-beat frames while port 3 also requests → grants alternate 0,3,0,3; port 0 never gets two consecutive grants.
- Timeout build, TIMEOUT_CYCLES=8: port 1 sends 1 beat, then tvalid=0 for 8 cycles → master shows a tlast beat with tstrb=0x00 and tdata=0, then timeout_o pulses. Port 1's remaining 2 beats are accepted and not forwarded, then port 1 is re-arbitrated normally.
- Assert reset during beat 2 of a 4-beat frame → the next cycle has grant_o=0, busy_o=0 and all treadies 0. After reset, port 0 wins first.
